// File: rtl/timer_bank.sv
// Multi-channel compare timer bank on the FemtoRV32 bus: one shared prescaler,
// per-channel periodic/one-shot counters, write-1-to-clear pending flags and a masked IRQ.
module timer_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                select,
    input  logic [7:0]          addr,
    input  logic [3:0]          we,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irq,
    output logic [CHANNELS-1:0] irq_vec
);
    localparam logic [1:0] REG_COMPARE = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_PEND    = 2'd0;
    localparam logic [1:0] REG_IRQEN   = 2'd1;
    localparam logic [1:0] REG_PRESC   = 2'd2;

    logic [WIDTH-1:0]         cmp_q [CHANNELS];
    logic [WIDTH-1:0]         cmp_d [CHANNELS];
    logic [WIDTH-1:0]         cnt_q [CHANNELS];
    logic [WIDTH-1:0]         cnt_d [CHANNELS];
    logic [CHANNELS-1:0]      en_q, en_d, per_q, per_d;
    logic [CHANNELS-1:0]      pend_q, pend_d, irqen_q, irqen_d, hit_c;
    logic [PRESCALE_BITS-1:0] presc_q, presc_d, psc_q, psc_d;
    logic                     wr_c, glob_wr_c, tick_c;
    logic [2:0]               ch_c;
    logic [1:0]               reg_c;
    logic                     unused_addr_lsbs;

    assign unused_addr_lsbs = ^addr[1:0];
    assign ch_c      = addr[6:4];
    assign reg_c     = addr[3:2];
    assign wr_c      = select && (we != 4'b0000);
    assign glob_wr_c = wr_c && addr[7] && (ch_c == 3'd0);
    assign tick_c    = (psc_q == presc_q);

    // Replace only the strobed byte lanes of a register image.
    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] nw,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        psc_d   = tick_c ? '0 : psc_q + PRESCALE_BITS'(1);
        presc_d = presc_q;
        irqen_d = irqen_q;
        en_d    = en_q;
        per_d   = per_q;
        hit_c   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            cmp_d[c] = cmp_q[c];
            cnt_d[c] = cnt_q[c];
        end

        if (glob_wr_c && reg_c == REG_PRESC) begin
            presc_d = PRESCALE_BITS'(lane_merge(32'(presc_q), wdata, we));
            psc_d   = '0;
        end
        if (glob_wr_c && reg_c == REG_IRQEN && we[0]) begin
            irqen_d = wdata[CHANNELS-1:0];
        end

        // Tick behaviour first so that bus writes below take priority.
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (tick_c && en_q[c]) begin
                if (cnt_q[c] == cmp_q[c]) begin
                    hit_c[c] = 1'b1;
                    if (per_q[c]) cnt_d[c] = '0;
                    else          en_d[c]  = 1'b0;
                end else begin
                    cnt_d[c] = cnt_q[c] + WIDTH'(1);
                end
            end
            if (wr_c && !addr[7] && ch_c == 3'(c)) begin
                case (reg_c)
                    REG_COMPARE: cmp_d[c] = WIDTH'(lane_merge(32'(cmp_q[c]), wdata, we));
                    REG_COUNT:   cnt_d[c] = WIDTH'(lane_merge(32'(cnt_q[c]), wdata, we));
                    REG_CTRL: begin
                        if (we[0]) begin
                            en_d[c]  = wdata[0];
                            per_d[c] = wdata[1];
                            if (wdata[2]) cnt_d[c] = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        pend_d = pend_q;
        if (glob_wr_c && reg_c == REG_PEND && we[0]) begin
            pend_d = pend_q & ~wdata[CHANNELS-1:0];
        end
        pend_d = pend_d | hit_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cmp_q[c] <= '1;
                cnt_q[c] <= '0;
            end
            en_q    <= '0;
            per_q   <= '0;
            pend_q  <= '0;
            irqen_q <= '0;
            presc_q <= '0;
            psc_q   <= '0;
        end else begin
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
            irqen_q <= irqen_d;
            presc_q <= presc_d;
            psc_q   <= psc_d;
        end
    end

    // Read mux: side-effect free, zero outside implemented registers.
    always_comb begin
        rdata = '0;
        if (select) begin
            if (addr[7]) begin
                if (ch_c == 3'd0) begin
                    case (reg_c)
                        REG_PEND:  rdata = 32'(pend_q);
                        REG_IRQEN: rdata = 32'(irqen_q);
                        REG_PRESC: rdata = 32'(presc_q);
                        default:   rdata = '0;
                    endcase
                end
            end else begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (ch_c == 3'(c)) begin
                        case (reg_c)
                            REG_COMPARE: rdata = 32'(cmp_q[c]);
                            REG_COUNT:   rdata = 32'(cnt_q[c]);
                            REG_CTRL:    rdata = {30'd0, per_q[c], en_q[c]};
                            default:     rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign irq_vec = pend_q & irqen_q;
    assign irq     = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: bus stimulus pushes expectations from a behavioural
// register model; a negedge monitor pops and compares rdata and {irq, irq_vec}.
module tb_timer_bank;
    localparam int unsigned CH    = 4;
    localparam int unsigned W     = 12;
    localparam int unsigned PB    = 8;
    localparam int unsigned WMASK = (32'd1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          select;
    logic [7:0]    addr;
    logic [3:0]    we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;
    logic [CH-1:0] irq_vec;

    timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_BITS(PB)) dut (
        .clk(clk), .reset(reset), .select(select), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .irq(irq), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          kind;    // 0: rdata, 1: {irq, irq_vec}
        logic [7:0]  a;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model state
    int unsigned m_cmp[CH];
    int unsigned m_cnt[CH];
    bit          m_en[CH];
    bit          m_per[CH];
    int unsigned m_pend, m_irqen, m_presc, m_psc;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cmp[c] = WMASK; m_cnt[c] = 0; m_en[c] = 0; m_per[c] = 0;
        end
        m_pend = 0; m_irqen = 0; m_presc = 0; m_psc = 0;
    endfunction

    function automatic int unsigned mrg(int unsigned old, int unsigned nw, bit [3:0] be);
        int unsigned r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r = (r & ~(32'hFF << (8*b))) | (nw & (32'hFF << (8*b)));
        end
        return r;
    endfunction

    function automatic int unsigned model_read(bit [7:0] a);
        int unsigned ch = 32'(a[6:4]);
        int unsigned rg = 32'(a[3:2]);
        if (a[7]) begin
            if (ch != 0) return 0;
            case (rg)
                0: return m_pend;
                1: return m_irqen;
                2: return m_presc;
                default: return 0;
            endcase
        end
        if (ch >= CH) return 0;
        case (rg)
            0: return m_cmp[ch];
            1: return m_cnt[ch];
            2: return (m_per[ch] ? 32'd2 : 32'd0) | (m_en[ch] ? 32'd1 : 32'd0);
            default: return 0;
        endcase
    endfunction

    // One clock of the peripheral: tick effects, then bus writes which win.
    function automatic void model_step(bit s, bit [7:0] a, bit [3:0] w, int unsigned d);
        bit          wr   = s && (w != 0);
        int unsigned ch   = 32'(a[6:4]);
        int unsigned rg   = 32'(a[3:2]);
        bit          glob = wr && a[7] && (ch == 0);
        bit          tick = (m_psc == m_presc);
        int unsigned set  = 0;
        int unsigned old_cnt[CH];
        for (int c = 0; c < CH; c++) old_cnt[c] = m_cnt[c];
        m_psc = tick ? 0 : m_psc + 1;
        if (glob && rg == 2) begin
            m_presc = mrg(m_presc, d, w) & 32'hFF;
            m_psc   = 0;
        end
        for (int c = 0; c < CH; c++) begin
            if (tick && m_en[c]) begin
                if (m_cnt[c] == m_cmp[c]) begin
                    set = set | (32'd1 << c);
                    if (m_per[c]) m_cnt[c] = 0;
                    else          m_en[c]  = 0;
                end else begin
                    m_cnt[c] = (m_cnt[c] + 1) & WMASK;
                end
            end
        end
        if (wr && !a[7] && ch < CH) begin
            case (rg)
                0: m_cmp[ch] = mrg(m_cmp[ch], d, w) & WMASK;
                1: m_cnt[ch] = mrg(old_cnt[ch], d, w) & WMASK;
                2: if (w[0]) begin
                       m_en[ch]  = d[0];
                       m_per[ch] = d[1];
                       if (d[2]) m_cnt[ch] = 0;
                   end
                default: ;
            endcase
        end
        if (glob && rg == 0 && w[0]) m_pend = m_pend & ~d;
        m_pend = (m_pend | set) & 32'hF;
        if (glob && rg == 1 && w[0]) m_irqen = d & 32'hF;
    endfunction

    function automatic void push(string nm, bit kind, logic [7:0] a, logic [31:0] exp, logic [31:0] mask);
        exp_t e;
        e.nm = nm; e.kind = kind; e.a = a; e.exp = exp; e.mask = mask;
        exp_q.push_back(e);
    endfunction

    // One bus cycle; starts just after a posedge, ends just after the next.
    task automatic cyc(input bit s, input logic [7:0] a, input logic [3:0] w, input logic [31:0] d);
        int unsigned iv;
        select = s; addr = a; we = w; wdata = d;
        iv = m_pend & m_irqen;
        push("irq", 1'b1, a, iv | ((iv != 0) ? 32'h10 : 32'h0), 32'h1F);
        if (w == 4'h0) push(s ? "rdata" : "rdata_unselected", 1'b0, a, s ? model_read(a) : 32'h0, '1);
        @(posedge clk);
        if (!reset) model_step(s, a, w, d);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b1, a, 4'hF, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b1, a, 4'h0, 32'h0);
    endtask

    task automatic rdk(input string nm, input logic [7:0] a, input logic [31:0] exp, input logic [31:0] mask);
        push(nm, 1'b0, a, exp, mask);
        rd(a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 4'h0, 32'h0);
    endtask

    // Monitor: compare everything expected for this cycle away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = e.kind ? 32'({irq, irq_vec}) : rdata;
            n_tests++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL %s addr=%02h: got %08h expected %08h (mask %08h) at %0t",
                         e.nm, e.a, act, e.exp, e.mask, $time);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit          found;
        logic [7:0]  ra;
        logic [3:0]  rw;
        logic [31:0] rdv;
        reset = 1'b1; select = 1'b0; addr = '0; we = '0; wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        rdk("rst_compare", 8'h00, 32'h0000_0FFF, '1);
        rdk("rst_pending", 8'h80, 32'h0, '1);
        rdk("rst_prescale", 8'h88, 32'h0, '1);
        rdk("rst_ctrl", 8'h08, 32'h0, '1);

        // Periodic ch0, compare 3, no prescale
        wr(8'h88, 0); wr(8'h00, 3); wr(8'h84, 1); wr(8'h08, 3);
        for (int i = 0; i < 5; i++) rdk("count_seq", 8'h04, (i == 4) ? 32'd0 : 32'(i), '1);
        push("irq_after_match", 1'b1, 8'h80, 32'h11, 32'h1F);
        rdk("pend_after_match", 8'h80, 32'h1, 32'h1);
        wr(8'h08, 0); wr(8'h80, 1);
        push("irq_after_w1c", 1'b1, 8'h80, 32'h0, 32'h1F);
        rdk("pend_after_w1c", 8'h80, 32'h0, '1);

        // One-shot ch1, prescale 2
        wr(8'h88, 2); wr(8'h10, 1); wr(8'h18, 1);
        idle(12);
        rdk("oneshot_ctrl", 8'h18, 32'h0, '1);
        rdk("oneshot_count", 8'h14, 32'h1, '1);
        rdk("oneshot_pend", 8'h80, 32'h2, 32'h2);
        wr(8'h80, 2);
        idle(15);
        rdk("oneshot_no_refire", 8'h80, 32'h0, 32'h2);

        // W1C coinciding with a hardware set; COUNT write coinciding with a tick
        wr(8'h88, 0); wr(8'h08, 3);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_psc == m_presc && m_en[0] && m_cnt[0] == m_cmp[0]) begin
                cyc(1'b1, 8'h80, 4'h1, 32'h1);
                found = 1'b1;
            end else begin
                rd(8'h04);
            end
        end
        rdk("set_beats_w1c", 8'h80, 32'h1, 32'h1);
        wr(8'h04, 32'h10);
        rdk("count_write_beats_tick", 8'h04, 32'h10, '1);
        wr(8'h08, 0); wr(8'h80, 32'hF);

        // Compare below count: wraps through 2^W before matching
        wr(8'h30, 5); wr(8'h34, 6); wr(8'h38, 3);
        idle(4095);
        rdk("wrap_not_yet", 8'h80, 32'h0, '1);
        rdk("wrap_match", 8'h80, 32'h8, '1);
        wr(8'h38, 0); wr(8'h80, 32'hF);

        // All channels, masked interrupt
        wr(8'h84, 5);
        wr(8'h00, 2); wr(8'h10, 3); wr(8'h20, 4); wr(8'h30, 5);
        wr(8'h08, 7); wr(8'h18, 7); wr(8'h28, 7); wr(8'h38, 7);
        idle(30);
        wr(8'h08, 0); wr(8'h18, 0); wr(8'h28, 0); wr(8'h38, 0);
        push("irq_mask", 1'b1, 8'h80, 32'h15, 32'h1F);
        rdk("all_pending", 8'h80, 32'hF, '1);

        // Asynchronous reset mid-count with pending set
        wr(8'h08, 3);
        idle(3);
        reset = 1'b1;
        model_reset();
        push("irq_async_reset", 1'b1, 8'h00, 32'h0, 32'h1F);
        rdk("compare_in_reset", 8'h00, 32'h0000_0FFF, '1);
        reset = 1'b0;
        rdk("ctrl_after_reset", 8'h08, 32'h0, '1);
        rdk("count_after_reset", 8'h04, 32'h0, '1);
        cyc(1'b1, 8'h00, 4'b0001, 32'h1234_5678);
        rdk("byte_lane0", 8'h00, 32'h0000_0F78, '1);
        cyc(1'b1, 8'h00, 4'b0010, 32'h0000_AB00);
        rdk("byte_lane1", 8'h00, 32'h0000_0B78, '1);

        // Unimplemented space and bits
        wr(8'h50, 32'h55);
        rdk("bad_channel", 8'h50, 32'h0, '1);
        rdk("global_hole", 8'h8C, 32'h0, '1);
        rdk("global_alias", 8'h90, 32'h0, '1);
        wr(8'h84, 32'hFF);
        rdk("irqen_width", 8'h84, 32'hF, '1);
        wr(8'h88, 32'h1234);
        rdk("presc_width", 8'h88, 32'h34, '1);
        wr(8'h88, 0);
        idle(1);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                ra = {1'b1, 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom)};
            else
                ra = {1'b0, 3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 2'($urandom)};
            rw  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            rdv = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
            if (ra[7] && ra[3:2] == 2'd2 && $urandom_range(0, 3) != 0) rdv = rdv & 32'h3;
            cyc(1'b1, ra, rw, rdv);
        end
        idle(2);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Memory-mapped multi-channel timer peripheral on the FemtoRV32 CPU bus. Parametrised successor to the single 32-bit timer in the SoC top level.
- Provides CHANNELS independent compare timers behind one shared prescaler. Each channel runs periodic (auto-reload) or one-shot.
- Per-channel pending flags are write-1-to-clear, and each has an enable mask. All are OR'd onto the CPU interrupt line.

Parameters:
- CHANNELS, 4, number of timer channels; legal range 1..8.
- WIDTH, 32, counter/compare width in bits; legal range 8..32.
- PRESCALE_BITS, 8, width of the shared prescaler divisor register.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- select  in  1  block address decode from the top level.
- addr  in  8  byte address within block; addr[1:0] ignored.
- we  in  4  byte-lane write strobes (CPU mem_wmask).
- wdata  in  32  write data.
- rdata  out  32  read data, combinational; 0 when select=0.
- irq  out  1  OR of (pending & irq_enable).
- irq_vec  out  CHANNELS  pending & irq_enable, per channel.

Behaviour:
- Register map, per channel n (n = addr[6:4], addr[7]=0):
  - +0x0 COMPARE: R/W, byte-lane writes.
  - +0x4 COUNT: R/W; a write loads the counter.
  - +0x8 CTRL: bit0 enable, bit1 periodic (1) / one-shot (0), bit2 clear-count (self-clearing, reads 0).
  - +0xC: reads 0.
- Global registers (addr[7]=1):
  - 0x80 PENDING: read flags; write 1 clears that bit.
  - 0x84 IRQ_EN: R/W.
  - 0x88 PRESCALE: R/W.
  - Other addresses read 0.
- Channel indices >= CHANNELS, register bits above WIDTH, PENDING/IRQ_EN bits >= CHANNELS, and PRESCALE bits >= PRESCALE_BITS: writes ignored, reads 0.
- Writes occur when select and any we bit are set; only strobed byte lanes update. CTRL, PENDING and IRQ_EN act on we[0] only. Written values are visible on rdata the next cycle. Reads have no side effects.
- Prescaler:
  - Counter psc counts 0..PRESCALE; tick=1 in the cycle psc==PRESCALE, then psc<=0.
  - PRESCALE=0 gives tick every cycle.
  - A write to PRESCALE resets psc to 0.
- Channel, on a tick with enable=1:
  - If count==compare: set pending. Periodic: count<=0. One-shot: enable<=0 and count holds at compare.
  - Otherwise count<=count+1, wrapping modulo 2^WIDTH.
  - Periodic period is therefore (compare+1)*(PRESCALE+1) cycles.
  - compare=0 periodic fires on every tick.
  - Compare written below the current count: the counter wraps through 2^WIDTH before matching. No '>' reload.
- With enable=0, count and pending are frozen, except for bus writes.
- Priority, simultaneous events in one cycle:
  - Count: bus COUNT write or clear-count beats tick increment/reload.
  - Pending: hardware set beats W1C clear; the flag stays 1.
  - One-shot: CTRL write setting enable beats hardware auto-disable.
- Reset (async, any time, including mid-count):
  - All counts, psc, PENDING, IRQ_EN, CTRL and PRESCALE go to 0.
  - COMPARE goes to all-ones.
  - irq=0, irq_vec=0.
  - Counting begins only after software sets enable.
- irq and irq_vec are combinational from registered flags, so irq asserts the cycle after pending sets.

Test Plan:
- PRESCALE=0, ch0 COMPARE=3, CTRL=periodic|enable, IRQ_EN=1 -> PENDING[0] sets on the 4th tick after enable; count sequence 0,1,2,3,0; irq high until a W1C of 0x1 to 0x80.
- PRESCALE=2, ch1 COMPARE=1, one-shot -> pending after 6 cycles; CTRL.enable reads 0; COUNT reads 1 and holds; no further pending after W1C.
- W1C on PENDING in the same cycle as a ch0 match -> PENDING[0] remains 1. COUNT write of 0x10 coinciding with a tick -> COUNT reads 0x10.
- WIDTH=8, COMPARE=5, COUNT written 0x06 -> counter runs 0x06..0xFF, 0x00..0x05 before pending sets (256 ticks).
- Four channels with different COMPARE values, IRQ_EN=0b0101 -> irq_vec shows only channels 0 and 2; irq ignores pending on channels 1 and 3.
- Assert reset mid-count with pending set -> outputs go to 0 immediately (async); COMPARE reads 0xFFFFFFFF; a byte write with we=0b0001 to COMPARE changes only bits [7:0].
